fit_tracker_gen2: RTL and testbench

FIT_TRACKER_GEN2 -- requirements
Module: fit_tracker_gen2

---
 rtl/fit_tracker_gen2.sv | 175 +++++++++++++++++
 tb/tb_fit_tracker_gen2.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fit_tracker_gen2.sv
// rtl/fit_tracker_gen2.sv - step counter, distance, per-second rate, streak and early-window tracker
//
// Purpose: counts synchronised step pulses, derives distance, and once per
// second (TICKS_PER_SEC slowClk cycles) updates activity statistics.
// Ports:
//   slowClk    clock, rising edge
//   RESET      synchronous active-high reset
//   PULSES     asynchronous step pulse, one step per rising edge
//   EN         0 pauses step counting and time-keeping
//   SI         sticky step-count saturation flag
//   stepcnt    total steps (saturates at SAT_STEPS)
//   distance   stepcnt >> DIST_SHIFT
//   sec        early-window seconds whose rate exceeded LO_TH
//   sectime    credited high-activity seconds
//   peak_rate  highest completed-second rate
//   sec_tick   one-cycle pulse in the last tick of each second
module fit_tracker_gen2 #(
    parameter int STEP_W        = 14,
    parameter int SAT_STEPS     = 9999,
    parameter int DIST_SHIFT    = 10,
    parameter int TICKS_PER_SEC = 1000,
    parameter int RATE_W        = 9,
    parameter int HI_TH         = 63,
    parameter int LO_TH         = 32,
    parameter int STREAK_MIN    = 60,
    parameter int WIN_SECS      = 9,
    parameter int TIME_W        = 9
) (
    input  logic                         slowClk,
    input  logic                         RESET,
    input  logic                         PULSES,
    input  logic                         EN,
    output logic                         SI,
    output logic [STEP_W-1:0]            stepcnt,
    output logic [STEP_W-DIST_SHIFT-1:0] distance,
    output logic [3:0]                   sec,
    output logic [TIME_W-1:0]            sectime,
    output logic [RATE_W-1:0]            peak_rate,
    output logic                         sec_tick
);

    localparam int TICK_W = $clog2(TICKS_PER_SEC);
    localparam int EL_W   = $clog2(WIN_SECS + 2);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [STEP_W-1:0] SAT_V     = STEP_W'(SAT_STEPS);
    localparam logic [RATE_W-1:0] RATE_MAX  = '1;
    localparam logic [RATE_W-1:0] HI_V      = RATE_W'(HI_TH);
    localparam logic [RATE_W-1:0] LO_V      = RATE_W'(LO_TH);
    localparam logic [TIME_W-1:0] TIME_MAX  = '1;
    localparam logic [TIME_W-1:0] SM_V      = TIME_W'(STREAK_MIN);
    localparam logic [EL_W-1:0]   WIN_V     = EL_W'(WIN_SECS);
    localparam logic [EL_W-1:0]   EL_MAX    = EL_W'(WIN_SECS + 1);

    // Input synchroniser, edge detector and post-reset arming
    logic              sync1_q, sync2_q, prev_q;
    logic [1:0]        settle_q, settle_d;
    logic              arm_q, arm_d;
    // Counters and statistics
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [RATE_W-1:0] rate_q, rate_d, rate_fin;
    logic [TIME_W-1:0] streak_q, streak_d, streak_new;
    logic [EL_W-1:0]   elapsed_q, elapsed_d;
    logic [STEP_W-1:0] stepcnt_q, stepcnt_d;
    logic              si_q, si_d;
    logic [3:0]        sec_q, sec_d;
    logic [TIME_W-1:0] sectime_q, sectime_d;
    logic [TIME_W:0]   st_sum;
    logic [RATE_W-1:0] peak_q, peak_d;
    logic              step_ev, sec_end;

    // A step only counts once the synchronised input has been seen low after
    // reset; this stops a pulse held high through reset from looking like an edge.
    assign step_ev = sync2_q & ~prev_q & arm_q & EN;
    assign sec_end = EN & (tick_q == TICK_LAST);

    always_comb begin
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        // settle_q==2 means sync2_q now reflects PULSES sampled after reset
        arm_d    = arm_q | ((settle_q == 2'd2) & ~sync2_q);

        tick_d = tick_q;
        if (EN) begin
            tick_d = sec_end ? '0 : tick_q + TICK_W'(1);
        end

        stepcnt_d = stepcnt_q;
        if (step_ev && (stepcnt_q < SAT_V)) begin
            stepcnt_d = stepcnt_q + STEP_W'(1);
        end
        si_d = si_q | (stepcnt_d == SAT_V);

        // Final rate of the current second includes a step in the sec_tick cycle
        rate_fin = (step_ev && (rate_q != RATE_MAX)) ? rate_q + RATE_W'(1) : rate_q;
        rate_d   = sec_end ? '0 : rate_fin;

        if (rate_fin > HI_V) begin
            streak_new = (streak_q == TIME_MAX) ? TIME_MAX : streak_q + TIME_W'(1);
        end else begin
            streak_new = '0;
        end
        streak_d = sec_end ? streak_new : streak_q;

        // Reaching the streak threshold credits the whole streak at once
        st_sum = {1'b0, sectime_q};
        if (streak_new == SM_V) begin
            st_sum = st_sum + (TIME_W+1)'(STREAK_MIN);
        end else if (streak_new > SM_V) begin
            st_sum = st_sum + (TIME_W+1)'(1);
        end
        sectime_d = sectime_q;
        if (sec_end) begin
            sectime_d = (st_sum > {1'b0, TIME_MAX}) ? TIME_MAX : st_sum[TIME_W-1:0];
        end

        // elapsed_q < WIN_V means the ending second is within 1..WIN_SECS
        elapsed_d = elapsed_q;
        sec_d     = sec_q;
        peak_d    = peak_q;
        if (sec_end) begin
            if (elapsed_q != EL_MAX) begin
                elapsed_d = elapsed_q + EL_W'(1);
            end
            if ((elapsed_q < WIN_V) && (rate_fin > LO_V) && (sec_q != 4'hF)) begin
                sec_d = sec_q + 4'd1;
            end
            if (rate_fin > peak_q) begin
                peak_d = rate_fin;
            end
        end
    end

    always_ff @(posedge slowClk) begin
        if (RESET) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            settle_q  <= 2'd0;
            arm_q     <= 1'b0;
            tick_q    <= '0;
            rate_q    <= '0;
            streak_q  <= '0;
            elapsed_q <= '0;
            stepcnt_q <= '0;
            si_q      <= 1'b0;
            sec_q     <= '0;
            sectime_q <= '0;
            peak_q    <= '0;
        end else begin
            sync1_q   <= PULSES;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            settle_q  <= settle_d;
            arm_q     <= arm_d;
            tick_q    <= tick_d;
            rate_q    <= rate_d;
            streak_q  <= streak_d;
            elapsed_q <= elapsed_d;
            stepcnt_q <= stepcnt_d;
            si_q      <= si_d;
            sec_q     <= sec_d;
            sectime_q <= sectime_d;
            peak_q    <= peak_d;
        end
    end

    assign SI        = si_q;
    assign stepcnt   = stepcnt_q;
    assign distance  = stepcnt_q[STEP_W-1:DIST_SHIFT];
    assign sec       = sec_q;
    assign sectime   = sectime_q;
    assign peak_rate = peak_q;
    assign sec_tick  = sec_end;

endmodule

// File: tb/tb_fit_tracker_gen2.sv
// tb/tb_fit_tracker_gen2.sv - self-checking bench for fit_tracker_gen2
module tb_fit_tracker_gen2;

    localparam int T = 160;

    logic       clk = 1'b0;
    logic       RESET, PULSES, EN;
    logic       SI, sec_tick;
    logic [13:0] stepcnt;
    logic [3:0] distance;
    logic [3:0] sec;
    logic [8:0] sectime;
    logic [8:0] peak_rate;

    int n_tests = 0;
    int n_fail  = 0;

    // per-second reference model
    int m_steps, m_streak, m_sectime, m_sec, m_elapsed, m_peak;

    fit_tracker_gen2 #(.TICKS_PER_SEC(T)) dut (
        .slowClk(clk), .RESET(RESET), .PULSES(PULSES), .EN(EN),
        .SI(SI), .stepcnt(stepcnt), .distance(distance), .sec(sec),
        .sectime(sectime), .peak_rate(peak_rate), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_steps = 0; m_streak = 0; m_sectime = 0;
        m_sec = 0; m_elapsed = 0; m_peak = 0;
    endtask

    task automatic model_second(input int r);
        m_steps = (m_steps + r > 9999) ? 9999 : m_steps + r;
        m_streak = (r > 63) ? ((m_streak + 1 > 511) ? 511 : m_streak + 1) : 0;
        if (m_streak == 60) m_sectime = m_sectime + 60;
        else if (m_streak > 60) m_sectime = m_sectime + 1;
        if (m_sectime > 511) m_sectime = 511;
        if (m_elapsed < 9) begin
            if (r > 32 && m_sec < 15) m_sec = m_sec + 1;
            m_elapsed = m_elapsed + 1;
        end
        if (r > m_peak) m_peak = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; PULSES = 1'b0; EN = 1'b1;
        cyc();
        RESET = 1'b0;
        model_reset();
    endtask

    // One full second starting at tick 0: n steps from cycle 4, sec_tick must
    // appear only in the last cycle.
    task automatic do_second(input int n);
        int bad = 0;
        for (int c = 0; c < T; c++) begin
            PULSES = (c >= 4 && c < 4 + 2*n && ((c - 4) % 2 == 0));
            @(negedge clk);
            if (sec_tick !== (c == T-1)) bad++;
            cyc();
        end
        PULSES = 1'b0;
        model_second(n);
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sec_tick_pattern: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({SI, stepcnt, distance, sec, sectime, peak_rate, sec_tick} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stepcnt=%0d SI=%0d sec=%0d sectime=%0d peak=%0d tick=%0d, required all 0",
                     stepcnt, SI, sec, sectime, peak_rate, sec_tick);
        end
        cyc();
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (4) cyc();
        for (int i = 0; i < 9998; i++) begin
            PULSES = 1'b1; cyc(); PULSES = 1'b0; cyc();
        end
        repeat (3) cyc();
        n_tests++;
        if (stepcnt !== 14'd9998 || SI !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_pre: got stepcnt=%0d SI=%0d, required 9998 0", stepcnt, SI);
        end
        PULSES = 1'b1; cyc(); PULSES = 1'b0; repeat (3) cyc();
        n_tests++;
        if (stepcnt !== 14'd9999 || SI !== 1'b1 || distance !== 4'd9) begin
            n_fail++;
            $display("FAIL sat_hit: got stepcnt=%0d SI=%0d dist=%0d, required 9999 1 9", stepcnt, SI, distance);
        end
        for (int i = 0; i < 5; i++) begin
            PULSES = 1'b1; cyc(); PULSES = 1'b0; cyc();
        end
        repeat (3) cyc();
        n_tests++;
        if (stepcnt !== 14'd9999 || SI !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: got stepcnt=%0d SI=%0d, required 9999 1", stepcnt, SI);
        end
    endtask

    task automatic test_early_window();
        do_reset();
        for (int s = 0; s < 12; s++) do_second(40);
        n_tests++;
        if (sec !== 4'd9 || peak_rate !== 9'd40 || sectime !== 9'd0 || stepcnt !== 14'(m_steps)) begin
            n_fail++;
            $display("FAIL early_window: got sec=%0d peak=%0d sectime=%0d steps=%0d, required 9 40 0 %0d",
                     sec, peak_rate, sectime, stepcnt, m_steps);
        end
    endtask

    task automatic test_streak();
        do_reset();
        for (int s = 0; s < 59; s++) do_second(64);
        n_tests++;
        if (sectime !== 9'd0) begin
            n_fail++; $display("FAIL streak_59: got %0d required 0", sectime);
        end
        do_second(64);
        n_tests++;
        if (sectime !== 9'd60) begin
            n_fail++; $display("FAIL streak_60: got %0d required 60", sectime);
        end
        do_second(64);
        n_tests++;
        if (sectime !== 9'd61) begin
            n_fail++; $display("FAIL streak_61: got %0d required 61", sectime);
        end
        do_second(10);
        for (int s = 0; s < 60; s++) do_second(64);
        n_tests++;
        if (sectime !== 9'd121 || sectime !== 9'(m_sectime)) begin
            n_fail++; $display("FAIL streak_121: got %0d required 121 (model %0d)", sectime, m_sectime);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        for (int s = 0; s < 70; s++) do_second(63);
        n_tests++;
        if (sectime !== 9'd0 || peak_rate !== 9'd63) begin
            n_fail++; $display("FAIL bound_hi: got sectime=%0d peak=%0d required 0 63", sectime, peak_rate);
        end
        do_reset();
        for (int s = 0; s < 10; s++) do_second(32);
        n_tests++;
        if (sec !== 4'd0) begin
            n_fail++; $display("FAIL bound_lo: got sec=%0d required 0", sec);
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int s = 0; s < 15; s++) begin
            n = $urandom_range(0, 70);
            do_second(n);
            n_tests++;
            if (stepcnt !== 14'(m_steps) || sec !== 4'(m_sec) || sectime !== 9'(m_sectime)
                || peak_rate !== 9'(m_peak)) begin
                n_fail++;
                $display("FAIL random_s%0d: got steps=%0d sec=%0d sectime=%0d peak=%0d, required %0d %0d %0d %0d",
                         s, stepcnt, sec, sectime, peak_rate, m_steps, m_sec, m_sectime, m_peak);
            end
        end
    endtask

    // A step event landing in the sec_tick cycle belongs to the ending second
    task automatic test_tick_edge_step();
        int bad = 0;
        do_reset();
        for (int c = 0; c < T; c++) begin
            PULSES = (c == 4 || c == 6 || c == T-3);
            @(negedge clk);
            if (sec_tick !== (c == T-1)) bad++;
            cyc();
        end
        PULSES = 1'b0;
        model_second(3);
        n_tests++;
        if (bad != 0 || peak_rate !== 9'(m_peak) || stepcnt !== 14'(m_steps)) begin
            n_fail++;
            $display("FAIL tick_edge_step: got peak=%0d steps=%0d badticks=%0d, required %0d %0d 0",
                     peak_rate, stepcnt, bad, m_peak, m_steps);
        end
    endtask

    task automatic test_pause();
        int bad = 0;
        int pbad = 0;
        logic [13:0] held;
        do_reset();
        do_second(5);
        for (int c = 0; c < 50; c++) begin
            PULSES = (c == 4 || c == 6 || c == 8);
            @(negedge clk);
            if (sec_tick !== 1'b0) bad++;
            cyc();
        end
        PULSES = 1'b0;
        cyc();
        held = stepcnt;
        EN = 1'b0;
        for (int p = 0; p < 100; p++) begin
            PULSES = ((p % 5) < 2);
            @(negedge clk);
            if (sec_tick !== 1'b0 || stepcnt !== held) pbad++;
            cyc();
        end
        PULSES = 1'b0;
        EN = 1'b1;
        n_tests++;
        if (pbad != 0 || held !== 14'(m_steps + 3)) begin
            n_fail++;
            $display("FAIL pause_hold: got %0d bad cycles, held=%0d, required 0 and %0d", pbad, held, m_steps + 3);
        end
        // one cycle was spent with EN=1 after cycle 49, so resume at tick 51
        for (int c = 51; c < T; c++) begin
            PULSES = (c == 54 || c == 56);
            @(negedge clk);
            if (sec_tick !== (c == T-1)) bad++;
            cyc();
        end
        PULSES = 1'b0;
        model_second(5);
        n_tests++;
        if (bad != 0 || stepcnt !== 14'(m_steps) || peak_rate !== 9'(m_peak)) begin
            n_fail++;
            $display("FAIL pause_resume: got steps=%0d peak=%0d badticks=%0d, required %0d %0d 0",
                     stepcnt, peak_rate, bad, m_steps, m_peak);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            PULSES = (c >= 4 && c < 14 && (c % 2 == 0));
            cyc();
        end
        n_tests++;
        if (stepcnt !== 14'd5) begin
            n_fail++; $display("FAIL mid_pre: got %0d required 5", stepcnt);
        end
        PULSES = 1'b1;
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        model_reset();
        @(negedge clk);
        n_tests++;
        if ({SI, stepcnt, distance, sec, sectime, peak_rate, sec_tick} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_zero: got stepcnt=%0d dist=%0d peak=%0d tick=%0d, required all 0",
                     stepcnt, distance, peak_rate, sec_tick);
        end
        cyc();
        // PULSES held high from reset through cycle 11, one real edge at 14
        for (int c = 1; c < T; c++) begin
            PULSES = (c < 12) || (c == 14);
            @(negedge clk);
            if (sec_tick !== (c == T-1)) bad++;
            if (c == 11 && stepcnt !== 14'd0) bad++;
            cyc();
        end
        PULSES = 1'b0;
        model_second(1);
        n_tests++;
        if (bad != 0 || stepcnt !== 14'(m_steps) || peak_rate !== 9'(m_peak)) begin
            n_fail++;
            $display("FAIL mid_reset_after: got steps=%0d peak=%0d bad=%0d, required %0d %0d 0",
                     stepcnt, peak_rate, bad, m_steps, m_peak);
        end
    endtask

    initial begin
        RESET = 1'b1; PULSES = 1'b0; EN = 1'b1;
        model_reset();
        repeat (2) cyc();
        RESET = 1'b0;
        test_reset();
        test_saturation();
        test_early_window();
        test_streak();
        test_boundary();
        test_random();
        test_tick_edge_step();
        test_pause();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
